// File: rtl/mem_access_ctrl_if.sv
// Memory beat bus between the MEM-stage access controller and memory.
// The controller is master; memory answers each beat with mem_ready.
interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: turns 32-bit loads/stores and 64-bit
// stores into one or two memory beats, stalling the pipeline meanwhile.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      MemWrite64,
    input  logic [31:0]               Adrs_MEM,
    input  logic [31:0]               Rt_data_MEM,
    input  logic [63:0]               Rt_data64_MEM,
    mem_access_ctrl_if.master         mem,
    output logic                      Stall,
    output logic [31:0]               Load_data,
    output logic                      Load_valid,
    output logic                      Err
);

    localparam int CW = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BEAT_LO = 2'd1,
        BEAT_HI = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   hi_data;
    logic          is_load;
    logic          is_wide;

    logic          req_valid;
    logic          multi_req;
    logic          misaligned;
    logic          beat_timeout;

    // Request decode and the wait-limit test for the current beat.
    always_comb begin
        req_valid    = MemRead | MemWrite | MemWrite64;
        multi_req    = (MemRead & MemWrite)
                     | (MemRead & MemWrite64)
                     | (MemWrite & MemWrite64);
        misaligned   = MemWrite64 ? (Adrs_MEM[2:0] != 3'd0)
                                  : (Adrs_MEM[1:0] != 2'd0);
        beat_timeout = ((wait_cnt + CW'(1)) == TMO);
    end

    // Stall is combinational so the pipeline freezes in the request cycle.
    always_comb begin
        Stall = 1'b0;
        unique case (state)
            IDLE:    Stall = req_valid;
            BEAT_LO: Stall = 1'b1;
            BEAT_HI: Stall = 1'b1;
            DONE:    Stall = 1'b0;
        endcase
    end

    // Access FSM with registered bus outputs and one-cycle status pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            hi_data       <= '0;
            is_load       <= 1'b0;
            is_wide       <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            Load_data     <= '0;
            Load_valid    <= 1'b0;
            Err           <= 1'b0;
        end else begin
            Load_valid <= 1'b0;
            Err        <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (multi_req || misaligned) begin
                            state <= DONE;
                            Err   <= 1'b1;
                        end else begin
                            state         <= BEAT_LO;
                            wait_cnt      <= '0;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= ~MemRead;
                            mem.mem_addr  <= Adrs_MEM;
                            mem.mem_wdata <= MemWrite64
                                           ? Rt_data64_MEM[31:0]
                                           : Rt_data_MEM;
                            hi_data       <= Rt_data64_MEM[63:32];
                            is_load       <= MemRead;
                            is_wide       <= MemWrite64;
                        end
                    end
                end
                BEAT_LO: begin
                    if (mem.mem_ready) begin
                        wait_cnt <= '0;
                        if (is_wide) begin
                            state         <= BEAT_HI;
                            mem.mem_addr  <= mem.mem_addr + 32'd4;
                            mem.mem_wdata <= hi_data;
                        end else begin
                            state       <= DONE;
                            mem.mem_req <= 1'b0;
                            if (is_load) begin
                                Load_data  <= mem.mem_rdata;
                                Load_valid <= 1'b1;
                            end
                        end
                    end else if (beat_timeout) begin
                        state       <= DONE;
                        wait_cnt    <= '0;
                        mem.mem_req <= 1'b0;
                        Err         <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                BEAT_HI: begin
                    if (mem.mem_ready) begin
                        state       <= DONE;
                        wait_cnt    <= '0;
                        mem.mem_req <= 1'b0;
                    end else if (beat_timeout) begin
                        state       <= DONE;
                        wait_cnt    <= '0;
                        mem.mem_req <= 1'b0;
                        Err         <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum wait cycles per beat with mem_req high and mem_ready low.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 MemRead  input  1  MEM-stage 32-bit load request.
REQ-005 MemWrite  input  1  MEM-stage 32-bit store request.
REQ-006 MemWrite64  input  1  MEM-stage 64-bit store request.
REQ-007 Adrs_MEM  input  32  byte address of the access.
REQ-008 Rt_data_MEM  input  32  store data for 32-bit store.
REQ-009 Rt_data64_MEM  input  64  store data for 64-bit store.
REQ-010 mem_ready  input  1  memory beat acknowledge.
REQ-011 mem_rdata  input  32  memory read data, valid when mem_ready is high.
REQ-012 mem_req  output  1  memory beat request, registered.
REQ-013 mem_we  output  1  1 = write beat, 0 = read beat, registered.
REQ-014 mem_addr  output  32  beat word address, registered.
REQ-015 mem_wdata  output  32  beat write data, registered.
REQ-016 Stall  output  1  holds IF..EXE/MEM pipeline registers.
REQ-017 Load_data  output  32  captured load result.
REQ-018 Load_valid  output  1  one-cycle pulse: Load_data valid.
REQ-019 Err  output  1  one-cycle pulse: access rejected or aborted.

Function
REQ-020 States SHALL be IDLE, BEAT_LO, BEAT_HI, DONE; 2-bit encoding.
REQ-021 Request valid = MemRead | MemWrite | MemWrite64, sampled only in IDLE.
REQ-022 Stall SHALL be combinational: high in IDLE when request valid, high in BEAT_LO and BEAT_HI, low in DONE and idle-without-request.
REQ-023 IDLE with more than one of MemRead/MemWrite/MemWrite64 high -> no memory beat, go DONE, Err pulses in the DONE cycle.
REQ-024 IDLE with misalignment (32-bit: Adrs_MEM[1:0]!=0; 64-bit: Adrs_MEM[2:0]!=0) -> no memory beat, go DONE, Err pulses in the DONE cycle.
REQ-025 Legal request in IDLE -> BEAT_LO next edge; same edge loads mem_req=1, mem_addr=Adrs_MEM, mem_we=~MemRead, mem_wdata=Rt_data_MEM (32-bit) or Rt_data64_MEM[31:0] (64-bit).
REQ-026 mem_req, mem_we, mem_addr, mem_wdata SHALL stay stable until mem_ready sampled high or timeout.
REQ-027 BEAT_LO, mem_ready high, 64-bit store -> BEAT_HI; mem_addr=Adrs_MEM+4, mem_wdata=Rt_data64_MEM[63:32], mem_req stays 1.
REQ-028 BEAT_LO, mem_ready high, 32-bit access -> DONE, mem_req=0; load: Load_data=mem_rdata.
REQ-029 BEAT_HI, mem_ready high -> DONE, mem_req=0.
REQ-030 Minimum latency: 32-bit access 3 cycles request-to-DONE-exit; 64-bit store 4 cycles.
REQ-031 Wait counter, 4+ bits, clears on each beat entry and on mem_ready; increments each cycle mem_req=1 and mem_ready=0.
REQ-032 Counter reaching TIMEOUT -> DONE, mem_req=0, Err pulses; partial 64-bit store not retried.
REQ-033 DONE: Stall low, request inputs ignored, unconditional return to IDLE next edge; Load_valid pulses here for a completed load only.
REQ-034 Load_data SHALL hold its value until the next completed load.
REQ-035 Address arithmetic modulo 2^32; Adrs_MEM=0xFFFFFFF8 high beat at 0xFFFFFFFC, no wrap error.

Reset
REQ-036 Reset high SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, Load_data=0, Load_valid=0, Err=0, counter=0.
REQ-037 Reset mid-beat SHALL abandon the access without Err; Stall follows REQ-022 from IDLE after release.

Verification
REQ-038 MemWrite=1, Adrs_MEM=0x100, Rt_data_MEM=0xDEADBEEF, mem_ready high on 2nd req cycle -> one beat, we=1, addr 0x100, Stall high 3 cycles, no Err.
REQ-039 MemWrite64=1, Adrs_MEM=0x208, Rt_data64_MEM=0x11223344_55667788, mem_ready=1 always -> beats (0x208,0x55667788), (0x20C,0x11223344); Stall 3 cycles.
REQ-040 MemRead=1, Adrs_MEM=0x40, mem_rdata=0xCAFEF00D at ack -> Load_valid one cycle, Load_data=0xCAFEF00D held afterwards.
REQ-041 MemWrite64=1, Adrs_MEM=0x204; then MemRead=MemWrite=1 -> each: zero mem_req cycles, Err one-cycle pulse.
REQ-042 MemRead=1, mem_ready held 0, TIMEOUT=15 -> mem_req high 15 cycles then low, Err pulse, Load_valid stays 0.
REQ-043 Reset asserted during BEAT_HI of a 64-bit store -> mem_req falls without clock edge; after release with no request, Stall=0, Err=0.
